// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: widths, ALU operation codes and the ID/EX control bundle.
package pipe_pkg;

  localparam int unsigned REG_W  = 5;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_NOR = 4'd5,
    ALU_SLT = 4'd6,
    ALU_SLL = 4'd7,
    ALU_SRL = 4'd8,
    ALU_SRA = 4'd9,
    ALU_LUI = 4'd10
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    reg_dst;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = ctrl_t'('0);

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: the load in EX writes a register the ID instruction reads.
module load_use_detect
  import pipe_pkg::*;
(
  input  logic             id_valid_i,
  input  logic             flush_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_uses_rt_i,
  input  logic             ex_valid_i,
  input  logic             ex_mem_read_i,
  input  logic [REG_W-1:0] ex_rt_i,
  output logic             hazard_o
);

  logic rs_match;
  logic rt_match;

  // Register 0 is hardwired, so a load targeting it never creates a dependency.
  always_comb begin
    rs_match = (ex_rt_i == id_rs_i);
    rt_match = id_uses_rt_i & (ex_rt_i == id_rt_i);
    hazard_o = id_valid_i & ~flush_i & ex_valid_i & ex_mem_read_i
             & (ex_rt_i != '0) & (rs_match | rt_match);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall, flush bubble and WB-to-ID bypass.
module id_ex_stage
  import pipe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ID_Valid,
  input  logic [DATA_W-1:0] ID_PCPlus4,
  input  logic [REG_W-1:0]  ID_RegRs,
  input  logic [REG_W-1:0]  ID_RegRt,
  input  logic [REG_W-1:0]  ID_RegRd,
  input  logic              ID_UsesRt,
  input  logic [DATA_W-1:0] ID_RsData,
  input  logic [DATA_W-1:0] ID_RtData,
  input  logic [DATA_W-1:0] ID_Imm,
  input  logic              ID_RegWrite,
  input  logic              ID_MemRead,
  input  logic              ID_MemWrite,
  input  logic              ID_MemtoReg,
  input  logic              ID_ALUSrc,
  input  logic              ID_RegDst,
  input  logic [3:0]        ID_ALUOp,
  input  logic              MEMWB_RegWrite,
  input  logic [REG_W-1:0]  MEMWB_RegRd,
  input  logic [DATA_W-1:0] MEMWB_WData,
  input  logic              Flush,
  output logic              PCWrite,
  output logic              IFID_Write,
  output logic              IDEX_Valid,
  output logic [DATA_W-1:0] IDEX_PCPlus4,
  output logic [REG_W-1:0]  IDEX_RegRs,
  output logic [REG_W-1:0]  IDEX_RegRt,
  output logic [REG_W-1:0]  IDEX_RegRd,
  output logic [DATA_W-1:0] IDEX_RsData,
  output logic [DATA_W-1:0] IDEX_RtData,
  output logic [DATA_W-1:0] IDEX_Imm,
  output logic              IDEX_RegWrite,
  output logic              IDEX_MemRead,
  output logic              IDEX_MemWrite,
  output logic              IDEX_MemtoReg,
  output logic              IDEX_ALUSrc,
  output logic              IDEX_RegDst,
  output logic [3:0]        IDEX_ALUOp,
  output logic [15:0]       StallCount
);

  logic              valid_q, valid_d;
  logic [DATA_W-1:0] pc4_q, pc4_d;
  logic [REG_W-1:0]  rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [DATA_W-1:0] rs_data_q, rs_data_d, rt_data_q, rt_data_d;
  logic [DATA_W-1:0] imm_q, imm_d;
  ctrl_t             ctrl_q, ctrl_d;
  logic [15:0]       stall_q;
  logic              hazard;
  logic              wb_live;

  load_use_detect u_lud (
    .id_valid_i    (ID_Valid),
    .flush_i       (Flush),
    .id_rs_i       (ID_RegRs),
    .id_rt_i       (ID_RegRt),
    .id_uses_rt_i  (ID_UsesRt),
    .ex_valid_i    (valid_q),
    .ex_mem_read_i (ctrl_q.mem_read),
    .ex_rt_i       (rt_q),
    .hazard_o      (hazard)
  );

  // Next bundle: ID values with WB bypass; control zeroed on flush, stall or empty slot.
  always_comb begin
    wb_live   = MEMWB_RegWrite & (MEMWB_RegRd != '0);
    pc4_d     = ID_PCPlus4;
    rs_d      = ID_RegRs;
    rt_d      = ID_RegRt;
    rd_d      = ID_RegRd;
    imm_d     = ID_Imm;
    rs_data_d = (wb_live && MEMWB_RegRd == ID_RegRs) ? MEMWB_WData : ID_RsData;
    rt_data_d = (wb_live && MEMWB_RegRd == ID_RegRt) ? MEMWB_WData : ID_RtData;
    valid_d   = ID_Valid;
    ctrl_d.reg_write  = ID_RegWrite;
    ctrl_d.mem_read   = ID_MemRead;
    ctrl_d.mem_write  = ID_MemWrite;
    ctrl_d.mem_to_reg = ID_MemtoReg;
    ctrl_d.alu_src    = ID_ALUSrc;
    ctrl_d.reg_dst    = ID_RegDst;
    ctrl_d.alu_op     = alu_op_e'(ID_ALUOp);
    if (Flush || hazard || !ID_Valid) begin
      valid_d = 1'b0;
      ctrl_d  = CTRL_BUBBLE;
    end
  end

  // Pipeline register and saturating stall counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      pc4_q     <= '0;
      rs_q      <= '0;
      rt_q      <= '0;
      rd_q      <= '0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      ctrl_q    <= CTRL_BUBBLE;
      stall_q   <= '0;
    end else begin
      valid_q   <= valid_d;
      pc4_q     <= pc4_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      rd_q      <= rd_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      ctrl_q    <= ctrl_d;
      if (hazard && stall_q != '1) stall_q <= stall_q + 16'd1;
    end
  end

  assign PCWrite       = ~hazard;
  assign IFID_Write    = ~hazard;
  assign IDEX_Valid    = valid_q;
  assign IDEX_PCPlus4  = pc4_q;
  assign IDEX_RegRs    = rs_q;
  assign IDEX_RegRt    = rt_q;
  assign IDEX_RegRd    = rd_q;
  assign IDEX_RsData   = rs_data_q;
  assign IDEX_RtData   = rt_data_q;
  assign IDEX_Imm      = imm_q;
  assign IDEX_RegWrite = ctrl_q.reg_write;
  assign IDEX_MemRead  = ctrl_q.mem_read;
  assign IDEX_MemWrite = ctrl_q.mem_write;
  assign IDEX_MemtoReg = ctrl_q.mem_to_reg;
  assign IDEX_ALUSrc   = ctrl_q.alu_src;
  assign IDEX_RegDst   = ctrl_q.reg_dst;
  assign IDEX_ALUOp    = ctrl_q.alu_op;
  assign StallCount    = stall_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stall, $0, flush priority, bypass, saturation.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_Valid;
  logic [31:0] ID_PCPlus4;
  logic [4:0]  ID_RegRs, ID_RegRt, ID_RegRd;
  logic        ID_UsesRt;
  logic [31:0] ID_RsData, ID_RtData, ID_Imm;
  logic        ID_RegWrite, ID_MemRead, ID_MemWrite, ID_MemtoReg, ID_ALUSrc, ID_RegDst;
  logic [3:0]  ID_ALUOp;
  logic        MEMWB_RegWrite;
  logic [4:0]  MEMWB_RegRd;
  logic [31:0] MEMWB_WData;
  logic        Flush;
  logic        PCWrite, IFID_Write, IDEX_Valid;
  logic [31:0] IDEX_PCPlus4;
  logic [4:0]  IDEX_RegRs, IDEX_RegRt, IDEX_RegRd;
  logic [31:0] IDEX_RsData, IDEX_RtData, IDEX_Imm;
  logic        IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg, IDEX_ALUSrc, IDEX_RegDst;
  logic [3:0]  IDEX_ALUOp;
  logic [15:0] StallCount;

  int unsigned passed = 0;
  int unsigned total  = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .ID_Valid(ID_Valid), .ID_PCPlus4(ID_PCPlus4),
    .ID_RegRs(ID_RegRs), .ID_RegRt(ID_RegRt), .ID_RegRd(ID_RegRd), .ID_UsesRt(ID_UsesRt),
    .ID_RsData(ID_RsData), .ID_RtData(ID_RtData), .ID_Imm(ID_Imm),
    .ID_RegWrite(ID_RegWrite), .ID_MemRead(ID_MemRead), .ID_MemWrite(ID_MemWrite),
    .ID_MemtoReg(ID_MemtoReg), .ID_ALUSrc(ID_ALUSrc), .ID_RegDst(ID_RegDst), .ID_ALUOp(ID_ALUOp),
    .MEMWB_RegWrite(MEMWB_RegWrite), .MEMWB_RegRd(MEMWB_RegRd), .MEMWB_WData(MEMWB_WData),
    .Flush(Flush), .PCWrite(PCWrite), .IFID_Write(IFID_Write), .IDEX_Valid(IDEX_Valid),
    .IDEX_PCPlus4(IDEX_PCPlus4), .IDEX_RegRs(IDEX_RegRs), .IDEX_RegRt(IDEX_RegRt),
    .IDEX_RegRd(IDEX_RegRd), .IDEX_RsData(IDEX_RsData), .IDEX_RtData(IDEX_RtData),
    .IDEX_Imm(IDEX_Imm), .IDEX_RegWrite(IDEX_RegWrite), .IDEX_MemRead(IDEX_MemRead),
    .IDEX_MemWrite(IDEX_MemWrite), .IDEX_MemtoReg(IDEX_MemtoReg), .IDEX_ALUSrc(IDEX_ALUSrc),
    .IDEX_RegDst(IDEX_RegDst), .IDEX_ALUOp(IDEX_ALUOp), .StallCount(StallCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled at the falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // lw $rt, 0($2)
  task automatic drive_lw(input logic [4:0] rt);
    ID_Valid = 1; ID_PCPlus4 = 32'h0000_0104; ID_RegRs = 5'd2; ID_RegRt = rt; ID_RegRd = 5'd0;
    ID_UsesRt = 0; ID_RsData = 32'h0000_1000; ID_RtData = 32'h0; ID_Imm = 32'h0;
    ID_RegWrite = 1; ID_MemRead = 1; ID_MemWrite = 0; ID_MemtoReg = 1; ID_ALUSrc = 1;
    ID_RegDst = 0; ID_ALUOp = 4'd0;
  endtask

  // add $rd, $rs, $rt (uses_rt selectable)
  task automatic drive_add(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic uses_rt);
    ID_Valid = 1; ID_PCPlus4 = 32'h0000_0108; ID_RegRs = rs; ID_RegRt = rt; ID_RegRd = rd;
    ID_UsesRt = uses_rt; ID_RsData = 32'h0000_00AA; ID_RtData = 32'h0000_00BB; ID_Imm = 32'h0;
    ID_RegWrite = 1; ID_MemRead = 0; ID_MemWrite = 0; ID_MemtoReg = 0; ID_ALUSrc = 0;
    ID_RegDst = 1; ID_ALUOp = 4'd0;
  endtask

  initial begin
    // Reset with nonzero inputs everywhere
    rst = 1; Flush = 0;
    drive_lw(5'd8); ID_RsData = 32'hFFFF_FFFF; ID_Imm = 32'h1234_5678;
    MEMWB_RegWrite = 1; MEMWB_RegRd = 5'd8; MEMWB_WData = 32'hCAFE_F00D;
    @(negedge clk);
    step();
    chk("rst_valid", {31'b0, IDEX_Valid}, 32'd0);
    chk("rst_pc4", IDEX_PCPlus4, 32'd0);
    chk("rst_rsdata", IDEX_RsData, 32'd0);
    chk("rst_imm", IDEX_Imm, 32'd0);
    chk("rst_ctrl", {25'b0, IDEX_RegWrite, IDEX_MemRead, IDEX_MemWrite, IDEX_MemtoReg,
                     IDEX_ALUSrc, IDEX_RegDst, 1'b0}, 32'd0);
    chk("rst_regrt", {27'b0, IDEX_RegRt}, 32'd0);
    chk("rst_stall", {16'b0, StallCount}, 32'd0);
    chk("rst_pcwrite", {31'b0, PCWrite}, 32'd1);
    rst = 0; MEMWB_RegWrite = 0; MEMWB_RegRd = 5'd0; MEMWB_WData = 32'h0;

    // Load-use on rs
    drive_lw(5'd8);
    step();
    chk("lw_memread", {31'b0, IDEX_MemRead}, 32'd1);
    chk("lw_regrt", {27'b0, IDEX_RegRt}, 32'd8);
    drive_add(5'd8, 5'd9, 5'd10, 1'b1);
    #1;
    chk("lu_pcwrite", {31'b0, PCWrite}, 32'd0);
    chk("lu_ifid", {31'b0, IFID_Write}, 32'd0);
    step();
    chk("lu_bubble_rw", {31'b0, IDEX_RegWrite}, 32'd0);
    chk("lu_bubble_valid", {31'b0, IDEX_Valid}, 32'd0);
    chk("lu_stall1", {16'b0, StallCount}, 32'd1);
    chk("lu_pcwrite_after", {31'b0, PCWrite}, 32'd1);
    step();
    chk("lu_add_valid", {31'b0, IDEX_Valid}, 32'd1);
    chk("lu_add_rw", {31'b0, IDEX_RegWrite}, 32'd1);
    chk("lu_add_rd", {27'b0, IDEX_RegRd}, 32'd10);

    // rt matches but is not a source
    drive_lw(5'd8);
    step();
    drive_add(5'd3, 5'd8, 5'd11, 1'b0);
    #1;
    chk("nort_pcwrite", {31'b0, PCWrite}, 32'd1);
    step();
    chk("nort_valid", {31'b0, IDEX_Valid}, 32'd1);
    chk("nort_rs", {27'b0, IDEX_RegRs}, 32'd3);
    chk("nort_rsdata", IDEX_RsData, 32'h0000_00AA);
    chk("nort_stall", {16'b0, StallCount}, 32'd1);

    // Load to $0 never stalls
    drive_lw(5'd0);
    step();
    drive_add(5'd0, 5'd0, 5'd12, 1'b1);
    #1;
    chk("r0_pcwrite", {31'b0, PCWrite}, 32'd1);
    step();
    chk("r0_rw", {31'b0, IDEX_RegWrite}, 32'd1);

    // Flush coincident with a real hazard
    drive_lw(5'd8);
    step();
    drive_add(5'd8, 5'd9, 5'd13, 1'b1); Flush = 1;
    #1;
    chk("fl_pcwrite", {31'b0, PCWrite}, 32'd1);
    step();
    Flush = 0;
    chk("fl_valid", {31'b0, IDEX_Valid}, 32'd0);
    chk("fl_rw", {31'b0, IDEX_RegWrite}, 32'd0);
    chk("fl_stall", {16'b0, StallCount}, 32'd1);

    // WB bypass on both operands
    drive_add(5'd5, 5'd5, 5'd14, 1'b1); ID_RsData = 32'h0; ID_RtData = 32'h0000_0011;
    MEMWB_RegWrite = 1; MEMWB_RegRd = 5'd5; MEMWB_WData = 32'hDEAD_BEEF;
    step();
    chk("byp_rs", IDEX_RsData, 32'hDEAD_BEEF);
    chk("byp_rt", IDEX_RtData, 32'hDEAD_BEEF);
    // WB to $0 does not bypass
    MEMWB_RegRd = 5'd0; ID_RsData = 32'h0000_1234; ID_RtData = 32'h0000_5678;
    step();
    chk("byp0_rs", IDEX_RsData, 32'h0000_1234);
    chk("byp0_rt", IDEX_RtData, 32'h0000_5678);
    MEMWB_RegWrite = 0;

    // Empty ID slot
    ID_Valid = 0;
    step();
    chk("idle_valid", {31'b0, IDEX_Valid}, 32'd0);
    chk("idle_rw", {31'b0, IDEX_RegWrite}, 32'd0);

    // Reset during a stall
    drive_lw(5'd8);
    step();
    drive_add(5'd8, 5'd9, 5'd10, 1'b1);
    #1;
    chk("rs_pre_pcwrite", {31'b0, PCWrite}, 32'd0);
    rst = 1;
    step();
    chk("rs_stall", {16'b0, StallCount}, 32'd0);
    chk("rs_valid", {31'b0, IDEX_Valid}, 32'd0);
    chk("rs_memread", {31'b0, IDEX_MemRead}, 32'd0);
    chk("rs_pcwrite", {31'b0, PCWrite}, 32'd1);
    rst = 0;

    // Saturation: preload counter one below the ceiling
    drive_lw(5'd8);
    step();
    force dut.stall_q = 16'hFFFE;
    #1 release dut.stall_q;
    drive_add(5'd8, 5'd9, 5'd10, 1'b1);
    step();
    chk("sat_reach", {16'b0, StallCount}, 32'h0000_FFFF);
    drive_lw(5'd8);
    step();
    drive_add(5'd8, 5'd9, 5'd10, 1'b1);
    #1;
    chk("sat_pcwrite", {31'b0, PCWrite}, 32'd0);
    step();
    chk("sat_hold", {16'b0, StallCount}, 32'h0000_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  // Safety net so the run always ends
  initial begin
    #100000;
    $display("FAIL timeout: sequence did not complete, observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
